// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm snooze controller: state encoding and
// default second counts.
package alarm_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t RINGING = 2'd1;
  localparam state_t SNOOZE  = 2'd2;
  localparam state_t DONE    = 2'd3;

  localparam int unsigned SNOOZE_SEC_DFLT   = 32'd540;
  localparam int unsigned RING_TIMEOUT_DFLT = 32'd600;

endpackage

// File: rtl/alarm_snooze_ctrl_sec_timer.sv
// Seconds timer shared by the ringing and snooze intervals. A load always
// wins; increment/decrement only move on a sec_tick pulse.
module sec_timer #(
  parameter int unsigned TW   = 32'd10,
  parameter int unsigned LAST = 32'd599
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          sec_tick_i,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic          is_one_o,
  output logic          is_last_o
);

  localparam logic [TW-1:0] ONE      = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] LAST_VAL = TW'(LAST);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Next count: load, tick-qualified step up/down, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (sec_tick_i && inc_i) begin
      cnt_d = cnt_q + ONE;
    end else if (sec_tick_i && dec_i) begin
      cnt_d = cnt_q - ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {TW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_one_o  = (cnt_q == ONE);
  assign is_last_o = (cnt_q == LAST_VAL);

endmodule

// File: rtl/alarm_snooze_ctrl.sv
// Alarm ring controller: starts ringing on a rising alarm match while armed,
// handles bounded timed snoozes, dismiss, and ring timeout with a sticky
// missed flag.
module alarm_snooze_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned SNOOZE_SEC       = SNOOZE_SEC_DFLT,
  parameter int unsigned RING_TIMEOUT_SEC = RING_TIMEOUT_DFLT,
  parameter int unsigned MAX_SNOOZES      = 32'd3,
  parameter int unsigned TW               = 32'd10
) (
  input  logic       clk,
  input  logic       rst_btn,
  input  logic       sec_tick,
  input  logic       match,
  input  logic       enable,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       sound,
  output logic       snoozing,
  output logic [1:0] snoozes_left,
  output logic       missed
);

  localparam logic [1:0]    LEFT_INIT  = 2'(MAX_SNOOZES);
  localparam logic [TW-1:0] SNOOZE_VAL = TW'(SNOOZE_SEC);

  state_t        state_q, state_d;
  logic          match_q;
  logic [1:0]    left_q, left_d;
  logic          missed_q, missed_d;
  logic          start;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_inc;
  logic          tmr_dec;
  logic          tmr_is_one;
  logic          tmr_is_last;

  // A level already high when the alarm is armed must not start a ring.
  assign start = match & ~match_q;

  sec_timer #(
    .TW   (TW),
    .LAST (RING_TIMEOUT_SEC - 32'd1)
  ) u_timer (
    .clk_i      (clk),
    .rst_ni     (rst_btn),
    .sec_tick_i (sec_tick),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .inc_i      (tmr_inc),
    .dec_i      (tmr_dec),
    .is_one_o   (tmr_is_one),
    .is_last_o  (tmr_is_last)
  );

  // State, match history, snooze budget and missed flag registers.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state_q  <= IDLE;
      match_q  <= 1'b0;
      left_q   <= LEFT_INIT;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      match_q  <= match;
      left_q   <= left_d;
      missed_q <= missed_d;
    end
  end

  // Next state, timer control and budget/missed updates in priority order.
  always_comb begin
    state_d  = state_q;
    left_d   = left_q;
    missed_d = missed_q;
    tmr_load = 1'b0;
    tmr_val  = {TW{1'b0}};
    tmr_inc  = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_load = 1'b1;
        left_d   = LEFT_INIT;
        if (start && enable) begin
          state_d  = RINGING;
          missed_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RINGING: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (dismiss) begin
          state_d = DONE;
        end else if (snooze && (left_q != 2'd0)) begin
          state_d  = SNOOZE;
          tmr_load = 1'b1;
          tmr_val  = SNOOZE_VAL;
          left_d   = left_q - 2'd1;
        end else if (sec_tick && tmr_is_last) begin
          // A snooze on the timeout tick was taken above, so missed stays clear.
          state_d  = DONE;
          missed_d = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      SNOOZE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (dismiss) begin
          state_d = DONE;
        end else if (sec_tick && tmr_is_one) begin
          state_d  = RINGING;
          tmr_load = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      DONE: begin
        // Hold until the minute passes so the same match cannot re-trigger.
        if (!match) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registers only, so reset clears them immediately.
  always_comb begin
    sound        = (state_q == RINGING);
    snoozing     = (state_q == SNOOZE);
    snoozes_left = left_q;
    missed       = missed_q;
  end

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// Testbench for alarm_snooze_ctrl: directed scenarios followed by random
// stimulus, every cycle compared with a behavioural model of the alarm.
module tb_alarm_snooze_ctrl;

  localparam int SNZ  = 3;
  localparam int RTO  = 5;
  localparam int MAXS = 2;

  logic       clk;
  logic       rst_btn;
  logic       sec_tick;
  logic       match;
  logic       enable;
  logic       snooze;
  logic       dismiss;
  logic       sound;
  logic       snoozing;
  logic [1:0] snoozes_left;
  logic       missed;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit last_tick;

  // Behavioural model: what the alarm is doing, seconds elapsed in the
  // current ring or nap, snoozes used this event, and the missed flag.
  typedef enum {M_OFF, M_RING, M_NAP, M_HOLD} mmode_t;
  mmode_t m_mode;
  int     m_secs;
  int     m_used;
  bit     m_missed;
  bit     m_prev_match;

  alarm_snooze_ctrl #(
    .SNOOZE_SEC       (SNZ),
    .RING_TIMEOUT_SEC (RTO),
    .MAX_SNOOZES      (MAXS),
    .TW               (10)
  ) dut (
    .clk          (clk),
    .rst_btn      (rst_btn),
    .sec_tick     (sec_tick),
    .match        (match),
    .enable       (enable),
    .snooze       (snooze),
    .dismiss      (dismiss),
    .sound        (sound),
    .snoozing     (snoozing),
    .snoozes_left (snoozes_left),
    .missed       (missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_mode       = M_OFF;
    m_secs       = 0;
    m_used       = 0;
    m_missed     = 1'b0;
    m_prev_match = 1'b0;
  endfunction

  function automatic void model_clock();
    bit rise;
    rise         = match && !m_prev_match;
    m_prev_match = match;
    case (m_mode)
      M_OFF: begin
        m_used = 0;
        m_secs = 0;
        if (rise && enable) begin
          m_mode   = M_RING;
          m_missed = 1'b0;
        end
      end
      M_RING: begin
        if (!enable) m_mode = M_OFF;
        else if (dismiss) m_mode = M_HOLD;
        else if (snooze && m_used < MAXS) begin
          m_mode = M_NAP;
          m_used++;
          m_secs = 0;
        end else if (sec_tick) begin
          m_secs++;
          if (m_secs == RTO) begin
            m_mode   = M_HOLD;
            m_missed = 1'b1;
          end
        end
      end
      M_NAP: begin
        if (!enable) m_mode = M_OFF;
        else if (dismiss) m_mode = M_HOLD;
        else if (sec_tick) begin
          m_secs++;
          if (m_secs == SNZ) begin
            m_mode = M_RING;
            m_secs = 0;
          end
        end
      end
      default: begin
        if (!match) m_mode = M_OFF;
      end
    endcase
  endfunction

  // One clock: drive the tick, let the edge happen, update the model,
  // then compare all outputs 1 time unit after the edge.
  task automatic step();
    sec_tick = ((cyc % 10) == 9);
    @(posedge clk);
    if (!rst_btn) model_reset();
    else model_clock();
    #1;
    last_tick = sec_tick;
    check("sound", sound, (m_mode == M_RING) ? 1 : 0);
    check("snoozing", snoozing, (m_mode == M_NAP) ? 1 : 0);
    check("snoozes_left", snoozes_left, MAXS - m_used);
    check("missed", missed, m_missed);
    snooze   = 1'b0;
    dismiss  = 1'b0;
    sec_tick = 1'b0;
    cyc++;
  endtask

  task automatic run_ticks(input int n);
    int seen = 0;
    int budget = 0;
    while (seen < n && budget < 200) begin
      step();
      if (last_tick) seen++;
      budget++;
    end
    if (seen < n) check("tick_budget", seen, n);
  endtask

  initial begin
    int n;
    int budget;
    rst_btn  = 1'b0;
    sec_tick = 1'b0;
    match    = 1'b0;
    enable   = 1'b0;
    snooze   = 1'b0;
    dismiss  = 1'b0;
    model_reset();
    repeat (3) step();
    check("rst_sound", sound, 0);
    check("rst_left", snoozes_left, MAXS);
    check("rst_missed", missed, 0);
    rst_btn = 1'b1;
    enable  = 1'b1;

    // Reset and start; disarmed match and armed-while-high match.
    while (cyc < 20) step();
    match = 1'b1;
    step();
    check("start_sound", sound, 1);
    dismiss = 1'b1;
    step();
    match = 1'b0;
    step();
    enable = 1'b0;
    match  = 1'b1;
    step();
    check("noarm_sound", sound, 0);
    enable = 1'b1;
    repeat (2) step();
    check("held_level", sound, 0);
    match = 1'b0;
    step();

    // Snooze and resume.
    match = 1'b1;
    step();
    snooze = 1'b1;
    step();
    check("snz_sound", sound, 0);
    check("snz_snoozing", snoozing, 1);
    check("snz_left", snoozes_left, 1);
    run_ticks(SNZ);
    check("resume_sound", sound, 1);

    // Snooze exhaustion, dismiss, DONE hold.
    snooze = 1'b1;
    step();
    check("snz2_left", snoozes_left, 0);
    run_ticks(SNZ);
    snooze = 1'b1;
    step();
    check("snz_ignored", sound, 1);
    check("snz_ignored_left", snoozes_left, 0);
    dismiss = 1'b1;
    step();
    check("dismiss_sound", sound, 0);
    repeat (3) step();
    check("done_hold_left", snoozes_left, 0);
    match = 1'b0;
    repeat (2) step();
    check("idle_reload", snoozes_left, MAXS);

    // Timeout and sticky missed.
    match = 1'b1;
    step();
    n = 0;
    budget = 0;
    while (sound && budget < 200) begin
      step();
      if (last_tick) n++;
      budget++;
    end
    check("timeout_ticks", n, RTO);
    check("timeout_missed", missed, 1);
    match = 1'b0;
    repeat (2) step();
    check("missed_sticky", missed, 1);
    match = 1'b1;
    step();
    check("missed_clear", missed, 0);

    // Simultaneous dismiss+snooze, then snooze on the timeout tick.
    dismiss = 1'b1;
    snooze  = 1'b1;
    step();
    check("dm_sn_sound", sound, 0);
    check("dm_sn_snoozing", snoozing, 0);
    check("dm_sn_left", snoozes_left, MAXS);
    match = 1'b0;
    repeat (2) step();
    match = 1'b1;
    step();
    run_ticks(RTO - 1);
    budget = 0;
    while (((cyc % 10) != 9) && budget < 20) begin
      step();
      budget++;
    end
    snooze = 1'b1;
    step();
    check("to_snz_snoozing", snoozing, 1);
    check("to_snz_missed", missed, 0);

    // Asynchronous reset mid-snooze.
    step();
    #2;
    rst_btn = 1'b0;
    #1;
    check("arst_snoozing", snoozing, 0);
    check("arst_sound", sound, 0);
    check("arst_left", snoozes_left, MAXS);
    model_reset();
    match = 1'b0;
    repeat (2) step();
    rst_btn = 1'b1;
    step();

    // Disarm while ringing.
    match = 1'b1;
    step();
    check("ring_before_disarm", sound, 1);
    enable = 1'b0;
    step();
    check("disarm_sound", sound, 0);
    enable = 1'b1;
    match  = 1'b0;
    step();

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      enable  = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 29) == 0) match = ~match;
      snooze  = ($urandom_range(0, 14) == 0);
      dismiss = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 999) == 0) rst_btn = 1'b0;
      step();
      rst_btn = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
